// File: rtl/agu_tile_sched.sv
// agu_tile_sched: per-layer tile scheduler for the PE address-generation configuration stage.
//
// Accepts one layer command, walks the channel/row/column tile space (tx innermost, ch
// outermost) and, per tile, emits a single-cycle start with the tile's configuration. It then
// waits for the AGU completion pulse before issuing the next tile.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cmd_valid       layer command valid (taken only when idle)
//   cmd_ready       idle, command can be accepted
//   cmd_mode        AGU mode (01/11 fc, 00/10 conv)
//   cmd_idx_cnt     idx count per tile
//   cmd_trip_cnt    trip count per tile
//   cmd_tx_num      tile columns (0 treated as 1)
//   cmd_ty_num      tile rows (0 treated as 1)
//   cmd_ch_num      input channels (0 treated as 1)
//   cmd_cut_last    bottom tile row is one line short
//   agu_done        AGU finished current tile (pulse, honoured only while waiting)
//   start           one-cycle start to the AGU config register
//   mode, idx_cnt, trip_cnt, is_new, pad_code {R,L,D,U}, cut_y   per-tile configuration
//   busy            high from command accept through layer_done
//   layer_done      one-cycle pulse after the last tile completes
//
// Optional feature (macro AGU_TILE_SCHED_PERF_EN):
//   perf_tiles [15:0]  tiles issued in the current/last layer (saturating)
//   perf_wait  [31:0]  cycles spent waiting on the AGU (saturating)

module agu_tile_sched #(
    parameter int unsigned TW = 6,
    parameter int unsigned CW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_mode,
    input  logic [7:0]    cmd_idx_cnt,
    input  logic [7:0]    cmd_trip_cnt,
    input  logic [TW-1:0] cmd_tx_num,
    input  logic [TW-1:0] cmd_ty_num,
    input  logic [CW-1:0] cmd_ch_num,
    input  logic          cmd_cut_last,
    input  logic          agu_done,
    output logic          start,
    output logic [1:0]    mode,
    output logic [7:0]    idx_cnt,
    output logic [7:0]    trip_cnt,
    output logic          is_new,
    output logic [3:0]    pad_code,
    output logic          cut_y,
    output logic          busy,
    output logic          layer_done
`ifdef AGU_TILE_SCHED_PERF_EN
    ,
    output logic [15:0]   perf_tiles,
    output logic [31:0]   perf_wait
`endif
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    trip_q, trip_d;
    logic [TW-1:0] tx_num_q, tx_num_d;
    logic [TW-1:0] ty_num_q, ty_num_d;
    logic [CW-1:0] ch_num_q, ch_num_d;
    logic          cut_last_q, cut_last_d;
    logic [TW-1:0] tx_q, tx_d;
    logic [TW-1:0] ty_q, ty_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [3:0]    pad_q, pad_d;
    logic          is_new_q, is_new_d;
    logic          cut_y_q, cut_y_d;
    logic          load_tile;
    logic          tx_last, ty_last, ch_last;

    assign tx_last = (tx_q == tx_num_q - TW'(1));
    assign ty_last = (ty_q == ty_num_q - TW'(1));
    assign ch_last = (ch_q == ch_num_q - CW'(1));

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        idx_d      = idx_q;
        trip_d     = trip_q;
        tx_num_d   = tx_num_q;
        ty_num_d   = ty_num_q;
        ch_num_d   = ch_num_q;
        cut_last_d = cut_last_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        ch_d       = ch_q;
        pad_d      = pad_q;
        is_new_d   = is_new_q;
        cut_y_d    = cut_y_q;
        load_tile  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    mode_d     = cmd_mode;
                    idx_d      = cmd_idx_cnt;
                    trip_d     = cmd_trip_cnt;
                    tx_num_d   = (cmd_tx_num == '0) ? TW'(1) : cmd_tx_num;
                    ty_num_d   = (cmd_ty_num == '0) ? TW'(1) : cmd_ty_num;
                    ch_num_d   = (cmd_ch_num == '0) ? CW'(1) : cmd_ch_num;
                    cut_last_d = cmd_cut_last;
                    tx_d       = '0;
                    ty_d       = '0;
                    ch_d       = '0;
                    load_tile  = 1'b1;
                    state_d    = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (agu_done) begin
                    if (tx_last && ty_last && ch_last) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StIssue;
                        load_tile = 1'b1;
                        if (!tx_last) begin
                            tx_d = tx_q + TW'(1);
                        end else begin
                            tx_d = '0;
                            if (!ty_last) begin
                                ty_d = ty_q + TW'(1);
                            end else begin
                                ty_d = '0;
                                ch_d = ch_q + CW'(1);
                            end
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Tile flags are computed from the next-state counters so they are already
        // valid in the cycle start is raised and stay put through the wait.
        if (load_tile) begin
            pad_d    = {tx_d == tx_num_d - TW'(1), tx_d == '0,
                        ty_d == ty_num_d - TW'(1), ty_d == '0};
            is_new_d = (ch_d == '0);
            cut_y_d  = cut_last_d & (ty_d == ty_num_d - TW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= '0;
            idx_q      <= '0;
            trip_q     <= '0;
            tx_num_q   <= TW'(1);
            ty_num_q   <= TW'(1);
            ch_num_q   <= CW'(1);
            cut_last_q <= 1'b0;
            tx_q       <= '0;
            ty_q       <= '0;
            ch_q       <= '0;
            pad_q      <= '0;
            is_new_q   <= 1'b0;
            cut_y_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            trip_q     <= trip_d;
            tx_num_q   <= tx_num_d;
            ty_num_q   <= ty_num_d;
            ch_num_q   <= ch_num_d;
            cut_last_q <= cut_last_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            ch_q       <= ch_d;
            pad_q      <= pad_d;
            is_new_q   <= is_new_d;
            cut_y_q    <= cut_y_d;
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign start      = (state_q == StIssue);
    assign busy       = (state_q != StIdle);
    assign layer_done = (state_q == StDone);
    assign mode       = mode_q;
    assign idx_cnt    = idx_q;
    assign trip_cnt   = trip_q;
    assign pad_code   = pad_q;
    assign is_new     = is_new_q;
    assign cut_y      = cut_y_q;

`ifdef AGU_TILE_SCHED_PERF_EN
    logic [15:0] perf_tiles_q;
    logic [31:0] perf_wait_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_tiles_q <= '0;
            perf_wait_q  <= '0;
        end else if (state_q == StIdle && cmd_valid) begin
            perf_tiles_q <= '0;
            perf_wait_q  <= '0;
        end else begin
            if (state_q == StIssue && !(&perf_tiles_q)) begin
                perf_tiles_q <= perf_tiles_q + 16'd1;
            end
            if (state_q == StWait && !(&perf_wait_q)) begin
                perf_wait_q <= perf_wait_q + 32'd1;
            end
        end
    end

    assign perf_tiles = perf_tiles_q;
    assign perf_wait  = perf_wait_q;
`endif

endmodule

// File: tb/tb_agu_tile_sched.sv
// Directed self-checking bench for agu_tile_sched. Inputs change and outputs are sampled on
// the falling clock edge; a monitor logs the per-tile outputs at every start.

module tb_agu_tile_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [7:0] cmd_idx_cnt;
    logic [7:0] cmd_trip_cnt;
    logic [5:0] cmd_tx_num;
    logic [5:0] cmd_ty_num;
    logic [9:0] cmd_ch_num;
    logic       cmd_cut_last;
    logic       agu_done;
    logic       start;
    logic [1:0] mode;
    logic [7:0] idx_cnt;
    logic [7:0] trip_cnt;
    logic       is_new;
    logic [3:0] pad_code;
    logic       cut_y;
    logic       busy;
    logic       layer_done;
`ifdef AGU_TILE_SCHED_PERF_EN
    logic [15:0] perf_tiles;
    logic [31:0] perf_wait;
`endif

    agu_tile_sched #(.TW(6), .CW(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mode     (cmd_mode),
        .cmd_idx_cnt  (cmd_idx_cnt),
        .cmd_trip_cnt (cmd_trip_cnt),
        .cmd_tx_num   (cmd_tx_num),
        .cmd_ty_num   (cmd_ty_num),
        .cmd_ch_num   (cmd_ch_num),
        .cmd_cut_last (cmd_cut_last),
        .agu_done     (agu_done),
        .start        (start),
        .mode         (mode),
        .idx_cnt      (idx_cnt),
        .trip_cnt     (trip_cnt),
        .is_new       (is_new),
        .pad_code     (pad_code),
        .cut_y        (cut_y),
        .busy         (busy),
        .layer_done   (layer_done)
`ifdef AGU_TILE_SCHED_PERF_EN
        ,
        .perf_tiles   (perf_tiles),
        .perf_wait    (perf_wait)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int ld_cnt    = 0;
    logic [3:0] pad_log[$];
    logic       new_log[$];
    logic       cut_log[$];
    logic [1:0] mode_log[$];

    always @(negedge clk) begin
        if (start) begin
            start_cnt++;
            pad_log.push_back(pad_code);
            new_log.push_back(is_new);
            cut_log.push_back(cut_y);
            mode_log.push_back(mode);
        end
        if (layer_done) ld_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        pad_log.delete();
        new_log.delete();
        cut_log.delete();
        mode_log.delete();
    endtask

    // Presents a command for one cycle (or keeps it up if hold); returns in the ISSUE cycle.
    task automatic send_cmd(input int tx, input int ty, input int ch, input bit cut,
                            input int md, input bit hold);
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_tx_num   = 6'(tx);
        cmd_ty_num   = 6'(ty);
        cmd_ch_num   = 10'(ch);
        cmd_cut_last = cut;
        cmd_mode     = 2'(md);
        cmd_idx_cnt  = 8'h5A;
        cmd_trip_cnt = 8'hC3;
        cmd_valid    = 1'b1;
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        check("start_latency", 32'(start), 1);
    endtask

    // Answers each start with agu_done `delay` cycles later; returns in the cycle after the
    // last done (DONE cycle for the final tile).
    task automatic serve(input int delay, input int tiles);
        for (int t = 0; t < tiles; t++) begin
            int guard = 0;
            while (!start && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!start) begin
                check("start_timeout", 32'(start), 1);
                return;
            end
            repeat (delay) @(negedge clk);
            agu_done = 1'b1;
            @(negedge clk);
            agu_done = 1'b0;
        end
    endtask

    task automatic finish_layer(input string tag);
        check({tag, "_layer_done"}, 32'(layer_done), 1);
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(cmd_ready), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(cmd_ready), 1);
        check({tag, "_start"}, 32'(start), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ldone"}, 32'(layer_done), 0);
        check({tag, "_isnew"}, 32'(is_new), 0);
        check({tag, "_cut"}, 32'(cut_y), 0);
        check({tag, "_pad"}, 32'(pad_code), 0);
        check({tag, "_mode"}, 32'(mode), 0);
        check({tag, "_idx"}, 32'(idx_cnt), 0);
        check({tag, "_trip"}, 32'(trip_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_s;
        int base_l;
        logic [3:0] exp_pad2[6];
        exp_pad2 = '{4'b0101, 4'b0001, 4'b1001, 4'b0110, 4'b0010, 4'b1010};

        rst = 1'b1; cmd_valid = 1'b0; agu_done = 1'b0; cmd_mode = '0;
        cmd_idx_cnt = '0; cmd_trip_cnt = '0; cmd_tx_num = '0; cmd_ty_num = '0;
        cmd_ch_num = '0; cmd_cut_last = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;

        // Single tile, done 3 cycles after start.
        clear_logs(); base_s = start_cnt;
        send_cmd(1, 1, 1, 0, 0, 0);
        check("t1_idx", 32'(idx_cnt), 'h5A);
        check("t1_trip", 32'(trip_cnt), 'hC3);
        serve(3, 1);
        finish_layer("t1");
        check("t1_starts", 32'(start_cnt - base_s), 1);
        if (pad_log.size() == 1) begin
            check("t1_pad", 32'(pad_log[0]), 'hF);
            check("t1_isnew", 32'(new_log[0]), 1);
        end else check("t1_logsize", 32'(pad_log.size()), 1);

        // 3x2 tiles, cut bottom row, immediate done.
        clear_logs(); base_s = start_cnt;
        send_cmd(3, 2, 1, 1, 0, 0);
        serve(1, 6);
        finish_layer("t2");
        check("t2_starts", 32'(start_cnt - base_s), 6);
        if (pad_log.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("t2_pad%0d", i), 32'(pad_log[i]), 32'(exp_pad2[i]));
                check($sformatf("t2_cut%0d", i), 32'(cut_log[i]), (i >= 3) ? 1 : 0);
            end
        end else check("t2_logsize", 32'(pad_log.size()), 6);

        // Four channels on one tile, fc mode.
        clear_logs(); base_s = start_cnt;
        send_cmd(1, 1, 4, 0, 1, 0);
        serve(2, 4);
        finish_layer("t3");
        check("t3_starts", 32'(start_cnt - base_s), 4);
        if (pad_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t3_isnew%0d", i), 32'(new_log[i]), (i == 0) ? 1 : 0);
                check($sformatf("t3_pad%0d", i), 32'(pad_log[i]), 'hF);
                check($sformatf("t3_mode%0d", i), 32'(mode_log[i]), 1);
            end
        end else check("t3_logsize", 32'(pad_log.size()), 4);

        // Stray agu_done in IDLE and ISSUE; cmd_valid held while busy.
        @(negedge clk); agu_done = 1'b1;
        @(negedge clk); agu_done = 1'b0;
        check("b_idle_done_start", 32'(start), 0);
        check("b_idle_done_ready", 32'(cmd_ready), 1);
        clear_logs(); base_s = start_cnt; base_l = ld_cnt;
        send_cmd(2, 1, 1, 0, 0, 1);
        agu_done = 1'b1;
        @(negedge clk); agu_done = 1'b0;
        repeat (3) @(negedge clk);
        check("b_issue_done_start", 32'(start), 0);
        check("b_issue_done_busy", 32'(busy), 1);
        check("b_issue_done_pad", 32'(pad_code), 'h7);
        agu_done = 1'b1;
        @(negedge clk); agu_done = 1'b0;
        check("b_tile2_pad", 32'(pad_code), 'hB);
        serve(1, 1);
        cmd_valid = 1'b0;
        finish_layer("b");
        repeat (4) @(negedge clk);
        check("b_starts", 32'(start_cnt - base_s), 2);
        check("b_ldone_cnt", 32'(ld_cnt - base_l), 1);
        check("b_no_extra_cmd", 32'(start), 0);

        // All count fields zero -> one tile.
        clear_logs(); base_s = start_cnt;
        send_cmd(0, 0, 0, 0, 2, 0);
        serve(1, 1);
        finish_layer("z");
        check("z_starts", 32'(start_cnt - base_s), 1);
        if (pad_log.size() == 1) check("z_pad", 32'(pad_log[0]), 'hF);

        // Reset while waiting on tile 2 of 6.
        base_s = start_cnt; base_l = ld_cnt;
        send_cmd(3, 2, 1, 1, 2, 0);
        serve(1, 1);
        @(negedge clk);
        check("r_in_wait", 32'(start), 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("r");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("r_starts", 32'(start_cnt - base_s), 2);
        check("r_no_ldone", 32'(ld_cnt - base_l), 0);
        base_s = start_cnt;
        send_cmd(2, 0, 0, 0, 0, 0);
        serve(1, 2);
        finish_layer("r2");
        repeat (2) @(negedge clk);
        check("r2_starts", 32'(start_cnt - base_s), 2);

`ifdef AGU_TILE_SCHED_PERF_EN
        send_cmd(2, 1, 1, 0, 0, 0);
        serve(4, 2);
        finish_layer("p");
        check("p_tiles", 32'(perf_tiles), 2);
        check("p_wait", perf_wait, 8);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
